eda_scan_ctrl: RTL and testbench

Raster-scan sequencer for the regional-maximum engine. It walks every pixel of the M×N image from (0,0) to (M-1,N-1), generates the center and eight neighbour addresses with boundary-valid flags, and handshakes each pixel with the comparator. It also drives the strobe RAM's control inputs (clear, new_pixel, update_strb, iterated_all, pre_center_addr, sel_row, sel_col) so the strobe RAM tracks the scan position.

---
 rtl/eda_pkg.sv | 46 ++++
 rtl/eda_nbr_addr_gen.sv | 39 +++
 rtl/eda_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_eda_scan_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eda_pkg.sv
// Shared types and constants for the regional-maximum engine: scan FSM states,
// neighbour indices and the window offset tables.
`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 4
`endif
`ifndef CFG_WINDOW_WIDTH
`define CFG_WINDOW_WIDTH 9
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 2
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 2
`endif
`ifndef CFG_ADDR_WIDTH
`define CFG_ADDR_WIDTH (`CFG_I_WIDTH + `CFG_J_WIDTH)
`endif

package eda_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COMPARE,
    ST_MARK,
    ST_ADVANCE,
    ST_DONE
  } scan_state_e;

  localparam int NB_UL = 7;
  localparam int NB_U  = 6;
  localparam int NB_UR = 5;
  localparam int NB_L  = 4;
  localparam int NB_R  = 3;
  localparam int NB_DL = 2;
  localparam int NB_D  = 1;
  localparam int NB_DR = 0;

  // Row/column offsets indexed by NB_* (element 7 is upleft).
  localparam int NB_DI [7:0] = '{-1, -1, -1,  0, 0,  1, 1, 1};
  localparam int NB_DJ [7:0] = '{-1,  0,  1, -1, 1, -1, 0, 1};

endpackage

// File: rtl/eda_nbr_addr_gen.sv
// Combinational 3x3 window address generator: center (i,j) to eight neighbour
// addresses with in-image flags; out-of-image neighbours alias the center.
module eda_nbr_addr_gen
  import eda_pkg::*;
#(
  parameter int M            = `CFG_M,
  parameter int N            = `CFG_N,
  parameter int WINDOW_WIDTH = `CFG_WINDOW_WIDTH,
  parameter int I_WIDTH      = `CFG_I_WIDTH,
  parameter int J_WIDTH      = `CFG_J_WIDTH,
  parameter int ADDR_WIDTH   = `CFG_ADDR_WIDTH
) (
  input  logic [I_WIDTH-1:0]                     i,
  input  logic [J_WIDTH-1:0]                     j,
  output logic [(WINDOW_WIDTH-1)*ADDR_WIDTH-1:0] nbr_addr,
  output logic [WINDOW_WIDTH-2:0]                nbr_valid
);

  localparam logic [I_WIDTH:0] M_EXT = (I_WIDTH+1)'(M);
  localparam logic [J_WIDTH:0] N_EXT = (J_WIDTH+1)'(N);

  genvar gi;
  generate
    for (gi = 0; gi < WINDOW_WIDTH-1; gi++) begin : g_nbr
      logic [I_WIDTH:0] ii;
      logic [J_WIDTH:0] jj;

      // One extra bit: -1 wraps to all-ones, so a single unsigned compare
      // catches both the lower and the upper image edge.
      assign ii = {1'b0, i} + (I_WIDTH+1)'(NB_DI[gi]);
      assign jj = {1'b0, j} + (J_WIDTH+1)'(NB_DJ[gi]);

      assign nbr_valid[gi] = (ii < M_EXT) && (jj < N_EXT);
      assign nbr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] =
        nbr_valid[gi] ? {ii[I_WIDTH-1:0], jj[J_WIDTH-1:0]} : {i, j};
    end
  endgenerate

endmodule

// File: rtl/eda_scan_ctrl.sv
// Raster-scan sequencer: walks the MxN image, handshakes each center with the
// comparator and drives the strobe RAM control inputs.
module eda_scan_ctrl
  import eda_pkg::*;
#(
  parameter int M            = `CFG_M,
  parameter int N            = `CFG_N,
  parameter int WINDOW_WIDTH = `CFG_WINDOW_WIDTH,
  parameter int I_WIDTH      = `CFG_I_WIDTH,
  parameter int J_WIDTH      = `CFG_J_WIDTH,
  parameter int ADDR_WIDTH   = `CFG_ADDR_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   start,
  input  logic                                   abort,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   cmp_req,
  input  logic                                   cmp_ack,
  output logic [ADDR_WIDTH-1:0]                  center_addr,
  output logic [(WINDOW_WIDTH-1)*ADDR_WIDTH-1:0] nbr_addr,
  output logic [WINDOW_WIDTH-2:0]                nbr_valid,
  output logic                                   clear,
  output logic                                   new_pixel,
  output logic                                   update_strb,
  output logic                                   iterated_all,
  output logic [ADDR_WIDTH-1:0]                  pre_center_addr,
  output logic [M-1:0]                           sel_row,
  output logic [M*N-1:0]                         sel_col
);

  localparam logic [I_WIDTH-1:0] I_LAST = I_WIDTH'(M-1);
  localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(N-1);

  scan_state_e        state_reg, state_next;
  logic [I_WIDTH-1:0] i_reg, i_next;
  logic [J_WIDTH-1:0] j_reg, j_next;
  logic               abort_flag_reg, abort_flag_next;
  logic               iterated_all_reg, iterated_all_next;
  logic [I_WIDTH-1:0] i_adv;
  logic [J_WIDTH-1:0] j_adv;
  logic               is_last;
  logic               in_scan;

  // Raster successor of the current position.
  always_comb begin
    if (j_reg == J_LAST) begin
      j_adv = '0;
      i_adv = i_reg + I_WIDTH'(1);
    end else begin
      j_adv = j_reg + J_WIDTH'(1);
      i_adv = i_reg;
    end
  end

  assign is_last = (i_reg == I_LAST) && (j_reg == J_LAST);
  assign in_scan = (state_reg == ST_COMPARE) || (state_reg == ST_MARK) ||
                   (state_reg == ST_ADVANCE);

  always_comb begin
    state_next        = state_reg;
    i_next            = i_reg;
    j_next            = j_reg;
    abort_flag_next   = abort_flag_reg;
    iterated_all_next = iterated_all_reg;

    // abort is checked first so it beats a simultaneous cmp_ack.
    if (in_scan && abort) begin
      state_next      = ST_CLEAR;
      abort_flag_next = 1'b1;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (start) state_next = ST_CLEAR;
        end
        ST_CLEAR: begin
          i_next            = '0;
          j_next            = '0;
          iterated_all_next = 1'b0;
          abort_flag_next   = 1'b0;
          state_next        = (abort_flag_reg || abort) ? ST_IDLE : ST_COMPARE;
        end
        ST_COMPARE: begin
          if (cmp_ack) state_next = ST_MARK;
        end
        ST_MARK: begin
          state_next = is_last ? ST_DONE : ST_ADVANCE;
        end
        ST_ADVANCE: begin
          i_next     = i_adv;
          j_next     = j_adv;
          state_next = ST_COMPARE;
        end
        ST_DONE: begin
          iterated_all_next = 1'b1;
          state_next        = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      i_reg            <= '0;
      j_reg            <= '0;
      abort_flag_reg   <= 1'b0;
      iterated_all_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      i_reg            <= i_next;
      j_reg            <= j_next;
      abort_flag_reg   <= abort_flag_next;
      iterated_all_reg <= iterated_all_next;
    end
  end

  assign busy            = (state_reg != ST_IDLE);
  assign done            = (state_reg == ST_DONE);
  assign cmp_req         = (state_reg == ST_COMPARE);
  assign clear           = (state_reg == ST_CLEAR);
  assign new_pixel       = (state_reg == ST_MARK) || (state_reg == ST_ADVANCE);
  assign update_strb     = (state_reg == ST_ADVANCE);
  assign iterated_all    = iterated_all_reg;
  assign center_addr     = {i_reg, j_reg};
  assign pre_center_addr = {i_reg, j_reg};

  // Strobe RAM selects point at the position being advanced to.
  genvar gi, gj;
  generate
    for (gi = 0; gi < M; gi++) begin : g_row
      assign sel_row[gi] = update_strb && (i_adv == I_WIDTH'(gi));
      for (gj = 0; gj < N; gj++) begin : g_col
        assign sel_col[gi*N + gj] = update_strb && (j_adv == J_WIDTH'(gj));
      end
    end
  endgenerate

  eda_nbr_addr_gen #(
    .M            (M),
    .N            (N),
    .WINDOW_WIDTH (WINDOW_WIDTH),
    .I_WIDTH      (I_WIDTH),
    .J_WIDTH      (J_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_nbr (
    .i         (i_reg),
    .j         (j_reg),
    .nbr_addr  (nbr_addr),
    .nbr_valid (nbr_valid)
  );

endmodule

// File: tb/tb_eda_scan_ctrl.sv
// Directed self-checking bench for eda_scan_ctrl on a 4x4 image.
module tb_eda_scan_ctrl;

  localparam int M = 4;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic        cmp_ack;
  logic        busy, done, cmp_req, clear, new_pixel, update_strb, iterated_all;
  logic [3:0]  center_addr, pre_center_addr;
  logic [31:0] nbr_addr;
  logic [7:0]  nbr_valid;
  logic [3:0]  sel_row;
  logic [15:0] sel_col;
  logic [6:0]  ctrl;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign ctrl = {busy, done, cmp_req, clear, new_pixel, update_strb, iterated_all};

  eda_scan_ctrl #(
    .M (M), .N (N), .WINDOW_WIDTH (9), .I_WIDTH (2), .J_WIDTH (2), .ADDR_WIDTH (4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .busy            (busy),
    .done            (done),
    .cmp_req         (cmp_req),
    .cmp_ack         (cmp_ack),
    .center_addr     (center_addr),
    .nbr_addr        (nbr_addr),
    .nbr_valid       (nbr_valid),
    .clear           (clear),
    .new_pixel       (new_pixel),
    .update_strb     (update_strb),
    .iterated_all    (iterated_all),
    .pre_center_addr (pre_center_addr),
    .sel_row         (sel_row),
    .sel_col         (sel_col)
  );

  task automatic apply_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    cmp_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Starts a scan with zero-wait acks and stops in the first COMPARE cycle of
  // the target center with cmp_ack dropped.
  task automatic run_to(input logic [3:0] target);
    bit found = 1'b0;
    cmp_ack = 1'b1;
    start   = 1'b1;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (cmp_req && center_addr == target) begin
        cmp_ack = 1'b0;
        found   = 1'b1;
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL run_to: center %h never reached, last center %h", target, center_addr);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if (ctrl !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, 7'b0);
    end
    tests++;
    if (center_addr !== 4'h0 || pre_center_addr !== 4'h0) begin
      fails++; $display("FAIL reset_addr: got %h/%h expected 0/0", center_addr, pre_center_addr);
    end
    tests++;
    if (nbr_valid !== 8'b0000_1011) begin
      fails++; $display("FAIL reset_nbr_valid: got %b expected %b", nbr_valid, 8'b0000_1011);
    end
    // (0,0): right={0,1}, down={1,0}, downright={1,1}; all others alias 0.
    tests++;
    if (nbr_addr !== 32'h0000_1045) begin
      fails++; $display("FAIL reset_nbr_addr: got %h expected %h", nbr_addr, 32'h0000_1045);
    end
    tests++;
    if (sel_row !== 4'b0 || sel_col !== 16'b0) begin
      fails++; $display("FAIL reset_sel: got %b/%h expected 0/0", sel_row, sel_col);
    end
    $display("[TB] test_reset complete");
  endtask

  task automatic test_full_scan();
    int cyc = 0;
    int np = 0;
    int done_at = -1;
    int done_cnt = 0;
    cmp_ack = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (clear !== 1'b1 || cmp_req !== 1'b0) begin
      fails++; $display("FAIL scan_clear: got clear=%b cmp_req=%b expected 1/0", clear, cmp_req);
    end
    while (cyc < 200 && done_at < 0) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        tests++;
        if (cmp_req !== 1'b1) begin
          fails++; $display("FAIL scan_first_req: got %b expected 1", cmp_req);
        end
      end
      if (new_pixel) np++;
      if (done) begin done_cnt++; done_at = cyc; end
    end
    // CLEAR + 16 pixels x 3 - 1 + DONE = 49 cycles, so DONE is 48 after CLEAR.
    tests++;
    if (done_at != 48) begin
      fails++; $display("FAIL scan_done_cycle: got %0d expected 48", done_at);
    end
    // 16 MARK cycles plus 15 ADVANCE cycles.
    tests++;
    if (np != 31) begin
      fails++; $display("FAIL scan_new_pixel_count: got %0d expected 31", np);
    end
    @(negedge clk);
    if (done) done_cnt++;
    tests++;
    if (done_cnt != 1) begin
      fails++; $display("FAIL scan_done_pulses: got %0d expected 1", done_cnt);
    end
    tests++;
    if (busy !== 1'b0 || iterated_all !== 1'b1) begin
      fails++; $display("FAIL scan_end_state: got busy=%b iterated_all=%b expected 0/1", busy, iterated_all);
    end
    $display("[TB] test_full_scan complete: done at %0d, %0d new_pixel", done_at, np);
  endtask

  task automatic test_abort();
    run_to(4'h5);
    cmp_ack = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if (clear !== 1'b1 || new_pixel !== 1'b0) begin
      fails++; $display("FAIL abort_to_clear: got clear=%b new_pixel=%b expected 1/0", clear, new_pixel);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || iterated_all !== 1'b0 || new_pixel !== 1'b0) begin
      fails++; $display("FAIL abort_idle: got busy=%b iterated_all=%b new_pixel=%b expected 0/0/0", busy, iterated_all, new_pixel);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || center_addr !== 4'h0) begin
      fails++; $display("FAIL abort_stays_idle: got busy=%b center=%h expected 0/0", busy, center_addr);
    end
    $display("[TB] test_abort complete");
  endtask

  task automatic test_nbr();
    apply_reset();
    run_to(4'hF);
    tests++;
    if (nbr_valid !== 8'b1101_0000) begin
      fails++; $display("FAIL nbr_valid_33: got %b expected %b", nbr_valid, 8'b1101_0000);
    end
    tests++;
    if (nbr_addr !== 32'hABFE_FFFF) begin
      fails++; $display("FAIL nbr_addr_33: got %h expected %h", nbr_addr, 32'hABFE_FFFF);
    end
    apply_reset();
    run_to(4'h6);
    tests++;
    if (nbr_valid !== 8'hFF) begin
      fails++; $display("FAIL nbr_valid_12: got %b expected %b", nbr_valid, 8'hFF);
    end
    tests++;
    if (nbr_addr !== 32'h1235_79AB) begin
      fails++; $display("FAIL nbr_addr_12: got %h expected %h", nbr_addr, 32'h1235_79AB);
    end
    apply_reset();
    $display("[TB] test_nbr complete");
  endtask

  task automatic test_wrap();
    run_to(4'h3);
    cmp_ack = 1'b1;
    @(negedge clk);
    tests++;
    if (new_pixel !== 1'b1 || update_strb !== 1'b0 || sel_row !== 4'b0) begin
      fails++; $display("FAIL wrap_mark: got np=%b us=%b row=%b expected 1/0/0000", new_pixel, update_strb, sel_row);
    end
    @(negedge clk);
    tests++;
    if (update_strb !== 1'b1 || sel_row !== 4'b0010 || sel_col[7:4] !== 4'b0001) begin
      fails++; $display("FAIL wrap_advance: got us=%b row=%b col1=%b expected 1/0010/0001", update_strb, sel_row, sel_col[7:4]);
    end
    tests++;
    if (sel_col !== 16'h1111) begin
      fails++; $display("FAIL wrap_sel_col: got %h expected %h", sel_col, 16'h1111);
    end
    @(negedge clk);
    tests++;
    if (cmp_req !== 1'b1 || center_addr !== 4'h4 || sel_row !== 4'b0 || sel_col !== 16'h0) begin
      fails++; $display("FAIL wrap_next_center: got req=%b center=%h row=%b col=%h expected 1/4/0/0", cmp_req, center_addr, sel_row, sel_col);
    end
    apply_reset();
    $display("[TB] test_wrap complete");
  endtask

  task automatic test_delayed_ack();
    run_to(4'h9);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      tests++;
      if (cmp_req !== 1'b1 || new_pixel !== 1'b0 || center_addr !== 4'h9 ||
          nbr_addr !== 32'h4568_ACDE) begin
        fails++;
        $display("FAIL delayed_hold[%0d]: got req=%b np=%b center=%h nbr=%h expected 1/0/9/4568acde",
                 k, cmp_req, new_pixel, center_addr, nbr_addr);
      end
    end
    cmp_ack = 1'b1;
    @(negedge clk);
    tests++;
    if (cmp_req !== 1'b0 || new_pixel !== 1'b1 || update_strb !== 1'b0) begin
      fails++; $display("FAIL delayed_mark: got req=%b np=%b us=%b expected 0/1/0", cmp_req, new_pixel, update_strb);
    end
    apply_reset();
    $display("[TB] test_delayed_ack complete");
  endtask

  task automatic test_reset_mid();
    run_to(4'hA);
    cmp_ack = 1'b1;
    @(negedge clk);
    tests++;
    if (new_pixel !== 1'b1 || update_strb !== 1'b0 || center_addr !== 4'hA) begin
      fails++; $display("FAIL midreset_mark: got np=%b us=%b center=%h expected 1/0/a", new_pixel, update_strb, center_addr);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (ctrl !== 7'b0 || center_addr !== 4'h0 || pre_center_addr !== 4'h0) begin
      fails++; $display("FAIL midreset_outputs: got ctrl=%b center=%h pre=%h expected 0/0/0", ctrl, center_addr, pre_center_addr);
    end
    tests++;
    if (nbr_valid !== 8'b0000_1011 || sel_row !== 4'b0 || sel_col !== 16'b0) begin
      fails++; $display("FAIL midreset_nbr: got valid=%b row=%b col=%h expected 00001011/0/0", nbr_valid, sel_row, sel_col);
    end
    @(negedge clk);
    reset_n = 1'b1;
    cmp_ack = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (clear !== 1'b1) begin
      fails++; $display("FAIL midreset_restart_clear: got %b expected 1", clear);
    end
    @(negedge clk);
    tests++;
    if (cmp_req !== 1'b1 || center_addr !== 4'h0) begin
      fails++; $display("FAIL midreset_rescan: got req=%b center=%h expected 1/0", cmp_req, center_addr);
    end
    apply_reset();
    $display("[TB] test_reset_mid complete");
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_abort();
    test_nbr();
    test_wrap();
    test_delayed_ack();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
